// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM microphone front end.
package pdm_pkg;

    // Microphone channel: selects which pdm_clk_o edge a sample is taken on.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } pdm_channel_t;

    // States of the microphone bit-clock generator.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } pdm_clk_state_t;

    // Smallest usable half period in clk_i cycles; smaller divisors are raised to this.
    localparam int PDM_MIN_DIVISOR = 2;

endpackage

// File: rtl/pdm_clock_generator.sv
// PDM bit-clock generator: half-period counter, divisor latch and clock FSM.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | clock stopped low, counter held at 0
// LOW   | low half period; disable returns to IDLE on the next cycle
// HIGH  | high half period; always runs to completion before leaving
//
// rise_o / fall_o pulse in the cycle after the terminal count of LOW / HIGH.
// pdm_clk_o is the state registered once more, so it toggles one cycle after
// the strobe; the top registers the strobe once, which lines valid_o up with
// the pdm_clk_o edge.
module pdm_clock_generator
    import pdm_pkg::*;
#(
    parameter int DIVISOR_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic [DIVISOR_WIDTH-1:0] divisor_i,
    output logic                     pdm_clk_o,
    output logic                     rise_o,
    output logic                     fall_o
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOW  = LOW;
    localparam logic [1:0] ST_HIGH = HIGH;

    localparam logic [DIVISOR_WIDTH-1:0] MIN_DIV = DIVISOR_WIDTH'(PDM_MIN_DIVISOR);
    localparam logic [DIVISOR_WIDTH-1:0] ONE     = DIVISOR_WIDTH'(1);

    logic [1:0]               state_q;
    logic [DIVISOR_WIDTH-1:0] cnt_q;
    logic [DIVISOR_WIDTH-1:0] div_q;
    logic [DIVISOR_WIDTH-1:0] div_clamped;
    logic                     tc;

    assign div_clamped = (divisor_i < MIN_DIV) ? MIN_DIV : divisor_i;
    // div_q is never below 2, so div_q - 1 cannot underflow.
    assign tc          = (cnt_q == (div_q - ONE));

    // Clock state machine, half-period counter, divisor re-latch and edge strobes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= MIN_DIV;
            pdm_clk_o <= 1'b0;
            rise_o    <= 1'b0;
            fall_o    <= 1'b0;
        end else begin
            rise_o    <= 1'b0;
            fall_o    <= 1'b0;
            pdm_clk_o <= (state_q == ST_HIGH);
            case (state_q)
                ST_LOW: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (tc) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                        div_q   <= div_clamped;
                        rise_o  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                ST_HIGH: begin
                    if (tc) begin
                        state_q <= enable_i ? ST_LOW : ST_IDLE;
                        cnt_q   <= '0;
                        div_q   <= div_clamped;
                        fall_o  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    cnt_q <= '0;
                    if (enable_i) begin
                        state_q <= ST_LOW;
                        div_q   <= div_clamped;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pdm_microphone_interface.sv
// PDM microphone front end: bit-clock generation, data synchronizer and
// edge-selected capture with a one-cycle valid strobe.
// Optional feature macro: PDM_STEREO_EN (capture on both edges, adds channel_o).
module pdm_microphone_interface
    import pdm_pkg::*;
#(
    parameter int DIVISOR_WIDTH = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic [DIVISOR_WIDTH-1:0] divisor_i,
    input  logic                     channel_i,
    input  logic                     pdm_data_i,
    output logic                     pdm_clk_o,
    output logic                     pdm_o,
    output logic                     valid_o
`ifdef PDM_STEREO_EN
    ,
    output logic                     channel_o
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rise;
    logic                   fall;
    logic                   capture;

    pdm_clock_generator #(
        .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) u_clk_gen (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .enable_i (enable_i),
        .divisor_i(divisor_i),
        .pdm_clk_o(pdm_clk_o),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    // Metastability synchronizer for the asynchronous microphone data line.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_data_i};
        end
    end

`ifdef PDM_STEREO_EN
    logic unused_channel_i;
    assign unused_channel_i = channel_i;
    assign capture          = rise | fall;

    // Tag each stereo sample with the edge it was taken on.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            channel_o <= 1'b0;
        end else if (capture) begin
            channel_o <= fall;
        end
    end
`else
    assign capture = (channel_i == RIGHT) ? fall : rise;
`endif

    // Capture register: pdm_o holds its value between strobes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pdm_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= capture;
            if (capture) begin
                pdm_o <= sync_q[SYNC_STAGES-1];
            end
        end
    end

endmodule
